wbm_chan_arb: RTL and testbench

WBM_CHAN_ARB -- requirements
Module: wbm_chan_arb

---
 rtl/wbm_arb_pkg.sv | 50 +++++
 rtl/rr_pick.sv | 32 +++
 rtl/wbm_chan_arb.sv | 205 ++++++++++++++++++++
 tb/tb_wbm_chan_arb.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbm_arb_pkg.sv
// wbm_arb_pkg: shared types and constants for the Wishbone channel arbiter.
// Holds the arbiter state encoding, the termination encoding and the legal
// watchdog limit range, plus small helpers used by the arbiter.
package wbm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        TERM_NONE = 2'd0,
        TERM_ACK  = 2'd1,
        TERM_RTY  = 2'd2,
        TERM_ERR  = 2'd3
    } term_t;

    localparam int TMO_MIN = 16;
    localparam int TMO_MAX = 65535;

    // Collapse the three bridge termination strobes into one code (ack first).
    function automatic term_t term_enc(input logic ack, input logic rty, input logic err);
        term_t res;
        if (ack) begin
            res = TERM_ACK;
        end else if (rty) begin
            res = TERM_RTY;
        end else if (err) begin
            res = TERM_ERR;
        end else begin
            res = TERM_NONE;
        end
        return res;
    endfunction

    // Clamp a requested watchdog limit into the supported counter range.
    function automatic logic [15:0] tmo_limit(input int cyc_lim);
        logic [15:0] res;
        if (cyc_lim < TMO_MIN) begin
            res = 16'(TMO_MIN);
        end else if (cyc_lim > TMO_MAX) begin
            res = 16'(TMO_MAX);
        end else begin
            res = 16'(cyc_lim);
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker. Scans the request vector
// starting at (last_i + 1) mod NCH and returns a one-hot grant (0 if none).
module rr_pick
    import wbm_arb_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int IDXW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [NCH-1:0]  grant_o
);

    logic [IDXW-1:0] idx_s;
    logic            hit_s;
    logic            found_s;

    // First requester after the last owner, in wrap-around order, wins.
    always_comb begin
        grant_o = {NCH{1'b0}};
        found_s = 1'b0;
        idx_s   = {IDXW{1'b0}};
        hit_s   = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            idx_s          = IDXW'((int'(last_i) + k) % NCH);
            hit_s          = req_i[idx_s] & ~found_s;
            grant_o[idx_s] = grant_o[idx_s] | hit_s;
            found_s        = found_s | hit_s;
        end
    end

endmodule

// File: rtl/wbm_chan_arb.sv
// wbm_chan_arb: multiplexes NCH Wishbone master channels onto a single bridge
// slave port. Round-robin grant registered in IDLE, held while the owner keeps
// cyc high, released to IDLE when it drops. Optional stall watchdog is enabled
// by defining WBM_CHAN_ARB_WDT_EN; without it a stalled owner keeps the bus.
module wbm_chan_arb
    import wbm_arb_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = 64,
    parameter int TMO_CYC = 1024
) (
    input  logic              PCI_CLK,
    input  logic              PCI_RSTn,
    input  logic [NCH-1:0]    ch_cyc_i,
    input  logic [NCH-1:0]    ch_stb_i,
    input  logic [NCH-1:0]    ch_we_i,
    input  logic [NCH-1:0]    ch_cab_i,
    input  logic [4*NCH-1:0]  ch_sel_i,
    input  logic [32*NCH-1:0] ch_adr_i,
    input  logic [DW*NCH-1:0] ch_dat_i,
    output logic [DW-1:0]     ch_dat_o,
    output logic [NCH-1:0]    ch_ack_o,
    output logic [NCH-1:0]    ch_rty_o,
    output logic [NCH-1:0]    ch_err_o,
    output logic              m_cyc_o,
    output logic              m_stb_o,
    output logic              m_we_o,
    output logic              m_cab_o,
    output logic [3:0]        m_sel_o,
    output logic [31:0]       m_adr_o,
    output logic [DW-1:0]     m_dat_o,
    input  logic [DW-1:0]     m_dat_i,
    input  logic              m_ack_i,
    input  logic              m_rty_i,
    input  logic              m_err_i,
    output logic [NCH-1:0]    grant_o
);

    localparam int IDXW = $clog2(NCH);

    arb_state_t      state_q, state_d;
    logic [NCH-1:0]  grant_q, grant_d;
    logic [NCH-1:0]  pick_s;
    logic [IDXW-1:0] last_q, last_d;
    logic [IDXW-1:0] owner_s;
    logic            g_cyc_s, g_stb_s, g_we_s, g_cab_s;
    logic [3:0]      g_sel_s;
    logic [31:0]     g_adr_s;
    logic [DW-1:0]   g_dat_s;
    logic            busy_s;
    logic            timeout_s;

    rr_pick #(.NCH(NCH), .IDXW(IDXW)) u_pick (
        .req_i   (ch_cyc_i),
        .last_i  (last_q),
        .grant_o (pick_s)
    );

    // AND-OR mux of the granted channel's bus signals and its index.
    always_comb begin
        g_cyc_s = 1'b0;
        g_stb_s = 1'b0;
        g_we_s  = 1'b0;
        g_cab_s = 1'b0;
        g_sel_s = 4'd0;
        g_adr_s = 32'd0;
        g_dat_s = {DW{1'b0}};
        owner_s = {IDXW{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            g_cyc_s = g_cyc_s | (grant_q[i] & ch_cyc_i[i]);
            g_stb_s = g_stb_s | (grant_q[i] & ch_stb_i[i]);
            g_we_s  = g_we_s  | (grant_q[i] & ch_we_i[i]);
            g_cab_s = g_cab_s | (grant_q[i] & ch_cab_i[i]);
            g_sel_s = g_sel_s | ({4{grant_q[i]}} & ch_sel_i[i*4 +: 4]);
            g_adr_s = g_adr_s | ({32{grant_q[i]}} & ch_adr_i[i*32 +: 32]);
            g_dat_s = g_dat_s | ({DW{grant_q[i]}} & ch_dat_i[i*DW +: DW]);
            owner_s = owner_s | (grant_q[i] ? IDXW'(i) : {IDXW{1'b0}});
        end
    end

    assign busy_s = (state_q == BUSY);

`ifdef WBM_CHAN_ARB_WDT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        any_term_s;
    logic        stall_s;

    assign any_term_s = (term_enc(m_ack_i, m_rty_i, m_err_i) != TERM_NONE);
    assign stall_s    = busy_s & g_cyc_s & g_stb_s & ~any_term_s;
    // Timeout fires on the stall clock that brings the count to the limit;
    // a termination in that same clock suppresses it via stall_s.
    assign timeout_s  = stall_s & (cnt_q == (tmo_limit(TMO_CYC) - 16'd1));

    // Count consecutive stalled strobe clocks; any other clock restarts.
    always_comb begin
        cnt_d = 16'd0;
        if (stall_s && !timeout_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = 16'd0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
        if (!PCI_RSTn) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [15:0] unused_tmo_s;

    assign unused_tmo_s = tmo_limit(TMO_CYC);
    assign timeout_s    = 1'b0;
`endif

    // Next-state logic: arbitrate in IDLE, hold the owner, release on cyc drop.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|ch_cyc_i) begin
                    grant_d = pick_s;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!g_cyc_s) begin
                    state_d = IDLE;
                    grant_d = {NCH{1'b0}};
                    last_d  = owner_s;
                end else if (timeout_s) begin
                    state_d = ABORT;
                end else begin
                    state_d = BUSY;
                end
            end
            ABORT: begin
                if (!g_cyc_s) begin
                    state_d = IDLE;
                    grant_d = {NCH{1'b0}};
                    last_d  = owner_s;
                end else begin
                    state_d = ABORT;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = {NCH{1'b0}};
            end
        endcase
    end

    // State, grant and last-owner registers; last resets so channel 0 goes first.
    always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
        if (!PCI_RSTn) begin
            state_q <= IDLE;
            grant_q <= {NCH{1'b0}};
            last_q  <= IDXW'(NCH - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Bridge-side controls follow the owner in BUSY; terminations gated by grant.
    always_comb begin
        m_cyc_o  = 1'b0;
        m_stb_o  = 1'b0;
        m_we_o   = 1'b0;
        m_cab_o  = 1'b0;
        m_sel_o  = 4'd0;
        m_adr_o  = 32'd0;
        m_dat_o  = {DW{1'b0}};
        ch_ack_o = {NCH{1'b0}};
        ch_rty_o = {NCH{1'b0}};
        ch_err_o = {NCH{1'b0}};
        if (busy_s) begin
            m_cyc_o  = g_cyc_s & ~timeout_s;
            m_stb_o  = g_stb_s & ~timeout_s;
            m_we_o   = g_we_s;
            m_cab_o  = g_cab_s;
            m_sel_o  = g_sel_s;
            m_adr_o  = g_adr_s;
            m_dat_o  = g_dat_s;
            ch_ack_o = grant_q & {NCH{m_ack_i}};
            ch_rty_o = grant_q & {NCH{m_rty_i}};
            ch_err_o = grant_q & {NCH{m_err_i | timeout_s}};
        end else begin
            m_cyc_o = 1'b0;
            m_stb_o = 1'b0;
        end
    end

    assign grant_o  = grant_q;
    assign ch_dat_o = m_dat_i;

endmodule

// File: tb/tb_wbm_chan_arb.sv
// tb_wbm_chan_arb: self-checking bench for wbm_chan_arb (NCH=4, DW=64, TMO_CYC=16).
// A per-cycle reference model (owner index, last index, stall count) is compared
// against every output at each falling edge; a vector table and hand-written
// sequences add fixed expectations for the key scenarios.
module tb_wbm_chan_arb;

    localparam int NCH = 4;
    localparam int DW  = 64;
    localparam int TMO = 16;

    logic              PCI_CLK = 1'b0;
    logic              PCI_RSTn = 1'b1;
    logic [NCH-1:0]    ch_cyc_i, ch_stb_i, ch_we_i, ch_cab_i;
    logic [4*NCH-1:0]  ch_sel_i;
    logic [32*NCH-1:0] ch_adr_i;
    logic [DW*NCH-1:0] ch_dat_i;
    logic [DW-1:0]     ch_dat_o;
    logic [NCH-1:0]    ch_ack_o, ch_rty_o, ch_err_o;
    logic              m_cyc_o, m_stb_o, m_we_o, m_cab_o;
    logic [3:0]        m_sel_o;
    logic [31:0]       m_adr_o;
    logic [DW-1:0]     m_dat_o;
    logic [DW-1:0]     m_dat_i;
    logic              m_ack_i, m_rty_i, m_err_i;
    logic [NCH-1:0]    grant_o;

    wbm_chan_arb #(.NCH(NCH), .DW(DW), .TMO_CYC(TMO)) dut (
        .PCI_CLK(PCI_CLK), .PCI_RSTn(PCI_RSTn),
        .ch_cyc_i(ch_cyc_i), .ch_stb_i(ch_stb_i), .ch_we_i(ch_we_i), .ch_cab_i(ch_cab_i),
        .ch_sel_i(ch_sel_i), .ch_adr_i(ch_adr_i), .ch_dat_i(ch_dat_i), .ch_dat_o(ch_dat_o),
        .ch_ack_o(ch_ack_o), .ch_rty_o(ch_rty_o), .ch_err_o(ch_err_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_cab_o(m_cab_o),
        .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_ack_i(m_ack_i), .m_rty_i(m_rty_i), .m_err_i(m_err_i), .grant_o(grant_o)
    );

    always #5 PCI_CLK = ~PCI_CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: -1 owner means nobody holds the bus.
    int m_owner = -1;
    int m_last  = NCH - 1;
    int m_stall = 0;
    bit m_abort = 1'b0;

    typedef struct {
        bit         rst;
        logic [3:0] cyc;
        logic       ack;
        logic [3:0] e_grant;
        logic       e_mcyc;
        logic [3:0] e_ack;
    } vec_t;
    vec_t tbl[21];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_to();
        bit r;
        logic [1:0] oi;
        r = 1'b0;
        oi = 2'(m_owner);
`ifdef WBM_CHAN_ARB_WDT_EN
        if (m_owner >= 0 && !m_abort)
            r = ch_cyc_i[oi] && ch_stb_i[oi] && !(m_ack_i || m_rty_i || m_err_i)
                && (m_stall + 1 == TMO);
`endif
        return r;
    endfunction

    task automatic check_model();
        logic [NCH-1:0] eg, ea, er, ee;
        logic ec, es, ew, eb;
        logic [3:0] esel;
        logic [31:0] eadr;
        logic [DW-1:0] edat;
        logic [1:0] oi;
        bit to;
        eg = 4'd0; ea = 4'd0; er = 4'd0; ee = 4'd0;
        ec = 1'b0; es = 1'b0; ew = 1'b0; eb = 1'b0;
        esel = 4'd0; eadr = 32'd0; edat = 64'd0;
        to = model_to();
        oi = 2'(m_owner);
        if (m_owner >= 0) begin
            eg = 4'b0001 << oi;
            if (!m_abort) begin
                ec   = ch_cyc_i[oi] & ~to;
                es   = ch_stb_i[oi] & ~to;
                ew   = ch_we_i[oi];
                eb   = ch_cab_i[oi];
                esel = ch_sel_i[oi*4 +: 4];
                eadr = ch_adr_i[oi*32 +: 32];
                edat = ch_dat_i[oi*DW +: DW];
                ea   = m_ack_i ? eg : 4'd0;
                er   = m_rty_i ? eg : 4'd0;
                ee   = (m_err_i || to) ? eg : 4'd0;
            end
        end
        chk("grant", 64'(grant_o), 64'(eg));
        chk("m_ctl", 64'({m_cyc_o, m_stb_o, m_we_o, m_cab_o, m_sel_o}), 64'({ec, es, ew, eb, esel}));
        chk("m_adr", 64'(m_adr_o), 64'(eadr));
        chk("m_dat", m_dat_o, edat);
        chk("ch_term", 64'({ch_ack_o, ch_rty_o, ch_err_o}), 64'({ea, er, ee}));
        chk("ch_dat", ch_dat_o, m_dat_i);
    endtask

    task automatic model_update();
        bit to;
        logic [1:0] oi;
        to = model_to();
        oi = 2'(m_owner);
        if (m_owner < 0) begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_last + k) % NCH;
                if (ch_cyc_i[2'(c)]) begin
                    m_owner = c;
                    break;
                end
            end
        end else if (!ch_cyc_i[oi]) begin
            m_last  = m_owner;
            m_owner = -1;
            m_abort = 1'b0;
            m_stall = 0;
        end else if (to) begin
            m_abort = 1'b1;
            m_stall = 0;
        end else if (!m_abort) begin
            m_stall = (ch_stb_i[oi] && !(m_ack_i || m_rty_i || m_err_i)) ? m_stall + 1 : 0;
        end
    endtask

    task automatic sample();
        @(negedge PCI_CLK);
        check_model();
    endtask

    task automatic advance();
        @(posedge PCI_CLK);
        model_update();
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic drive_idle();
        ch_cyc_i = 4'd0; ch_stb_i = 4'd0; ch_cab_i = 4'd0;
        m_ack_i = 1'b0; m_rty_i = 1'b0; m_err_i = 1'b0;
    endtask

    // Asynchronous reset pulse; outputs are checked before any clock edge.
    task automatic do_reset();
        PCI_RSTn = 1'b0;
        #2;
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_mctl", 64'({m_cyc_o, m_stb_o, m_we_o, m_cab_o, m_sel_o}), 64'd0);
        chk("rst_madr", 64'(m_adr_o), 64'd0);
        chk("rst_mdat", m_dat_o, 64'd0);
        chk("rst_term", 64'({ch_ack_o, ch_rty_o, ch_err_o}), 64'd0);
        @(negedge PCI_CLK);
        PCI_RSTn = 1'b1;
        m_owner = -1; m_abort = 1'b0; m_last = NCH - 1; m_stall = 0;
        advance();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000};
        tbl[1]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0000};
        tbl[2]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0001};
        tbl[3]  = '{1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000};
        tbl[4]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
        tbl[5]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000};
        tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001};
        tbl[7]  = '{1'b0, 4'b1110, 1'b0, 4'b0001, 1'b0, 4'b0000};
        tbl[8]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000};
        tbl[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010};
        tbl[10] = '{1'b0, 4'b1101, 1'b0, 4'b0010, 1'b0, 4'b0000};
        tbl[11] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000};
        tbl[12] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100};
        tbl[13] = '{1'b0, 4'b1011, 1'b0, 4'b0100, 1'b0, 4'b0000};
        tbl[14] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000};
        tbl[15] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000};
        tbl[16] = '{1'b0, 4'b0111, 1'b0, 4'b1000, 1'b0, 4'b0000};
        tbl[17] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000};
        tbl[18] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'b0000};
        tbl[19] = '{1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000};
        tbl[20] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};

        drive_idle();
        ch_we_i = 4'b1111;
        ch_sel_i = 16'hFFFF;
        m_dat_i = 64'h0;
        for (int c = 0; c < NCH; c++) begin
            ch_adr_i[c*32 +: 32] = 32'h1000 + 32'(c) * 32'h100;
            ch_dat_i[c*DW +: DW] = 64'h1111_0000_0000_0000 * 64'(c + 1);
        end
        ch_dat_i[0 +: DW] = 64'hA5A5_5A5A_0000_FFFF;
        #1;
        do_reset();

        // Single write on ch0, then four-way round robin from reset.
        for (int i = 0; i < 21; i++) begin
            if (tbl[i].rst) do_reset();
            ch_cyc_i = tbl[i].cyc;
            ch_stb_i = tbl[i].cyc;
            m_ack_i  = tbl[i].ack;
            sample();
            chk("tbl_grant", 64'(grant_o), 64'(tbl[i].e_grant));
            chk("tbl_mcyc", 64'(m_cyc_o), 64'(tbl[i].e_mcyc));
            chk("tbl_ack", 64'(ch_ack_o), 64'(tbl[i].e_ack));
            if (i == 1) begin
                chk("wr_adr", 64'(m_adr_o), 64'h1000);
                chk("wr_dat", m_dat_o, 64'hA5A5_5A5A_0000_FFFF);
            end
            advance();
        end

        // ch2 cab burst of 8 while ch1 keeps requesting.
        drive_idle();
        do_reset();
        ch_cyc_i = 4'b0100; ch_stb_i = 4'b0100; ch_cab_i = 4'b0100;
        tick();
        ch_cyc_i = 4'b0110; ch_stb_i = 4'b0110;
        for (int b = 0; b < 8; b++) begin
            m_ack_i = 1'b1;
            sample();
            chk("burst_grant", 64'(grant_o), 64'b0100);
            chk("burst_ack", 64'(ch_ack_o), 64'b0100);
            chk("burst_cab", 64'(m_cab_o), 64'd1);
            advance();
        end
        m_ack_i = 1'b0;
        ch_cyc_i = 4'b0010; ch_stb_i = 4'b0010; ch_cab_i = 4'b0000;
        tick();
        tick();
        sample();
        chk("burst_next", 64'(grant_o), 64'b0010);
        advance();
        drive_idle();
        tick();
        tick();

        // Retry on ch3: only ch3 sees it, grant held until ch3 drops.
        do_reset();
        ch_cyc_i = 4'b1000; ch_stb_i = 4'b1000;
        tick();
        ch_cyc_i = 4'b1001; ch_stb_i = 4'b1001; m_rty_i = 1'b1;
        sample();
        chk("rty_pulse", 64'(ch_rty_o), 64'b1000);
        chk("rty_noack", 64'({ch_ack_o, ch_err_o}), 64'd0);
        advance();
        m_rty_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("rty_hold", 64'(grant_o), 64'b1000);
            advance();
        end
        ch_cyc_i = 4'b0001; ch_stb_i = 4'b0001;
        tick();
        tick();
        sample();
        chk("rty_next", 64'(grant_o), 64'b0001);
        advance();
        drive_idle();
        tick();
        tick();

`ifdef WBM_CHAN_ARB_WDT_EN
        // Stall on ch1 with no termination: error at stall clock 16, then abort.
        do_reset();
        ch_cyc_i = 4'b0010; ch_stb_i = 4'b0010;
        tick();
        for (int k = 1; k <= TMO; k++) begin
            sample();
            if (k == TMO) begin
                chk("wdt_err", 64'(ch_err_o), 64'b0010);
                chk("wdt_mcyc", 64'(m_cyc_o), 64'd0);
            end else begin
                chk("wdt_noerr", 64'(ch_err_o), 64'd0);
            end
            advance();
        end
        m_ack_i = 1'b1;
        sample();
        chk("abort_ack", 64'(ch_ack_o), 64'd0);
        chk("abort_mcyc", 64'(m_cyc_o), 64'd0);
        chk("abort_grant", 64'(grant_o), 64'b0010);
        advance();
        m_ack_i = 1'b0;
        ch_cyc_i = 4'b0000; ch_stb_i = 4'b0000;
        tick();
        sample();
        chk("abort_idle", 64'(grant_o), 64'd0);
        advance();
        // Ack landing on stall clock 16 wins over the timeout.
        ch_cyc_i = 4'b0010; ch_stb_i = 4'b0010;
        tick();
        for (int k = 1; k <= TMO; k++) begin
            m_ack_i = (k == TMO);
            sample();
            if (k == TMO) begin
                chk("tie_ack", 64'(ch_ack_o), 64'b0010);
                chk("tie_noerr", 64'(ch_err_o), 64'd0);
                chk("tie_mcyc", 64'(m_cyc_o), 64'd1);
            end
            advance();
        end
        m_ack_i = 1'b0;
        tick();
        drive_idle();
        tick();
        tick();
`else
        // Without the watchdog a stalled owner keeps the bus.
        do_reset();
        ch_cyc_i = 4'b0010; ch_stb_i = 4'b0010;
        tick();
        for (int k = 1; k <= 3 * TMO; k++) begin
            sample();
            chk("stall_hold", 64'(grant_o), 64'b0010);
            chk("stall_mcyc", 64'(m_cyc_o), 64'd1);
            chk("stall_noerr", 64'(ch_err_o), 64'd0);
            advance();
        end
        drive_idle();
        tick();
        tick();
`endif

        // Reset mid-burst on ch2 with ch0 waiting: bus drops at once, ch0 next.
        do_reset();
        ch_cyc_i = 4'b0100; ch_stb_i = 4'b0100; ch_cab_i = 4'b0100;
        tick();
        ch_cyc_i = 4'b0101; ch_stb_i = 4'b0101;
        m_ack_i = 1'b1;
        tick();
        tick();
        m_ack_i = 1'b0;
        do_reset();
        sample();
        chk("post_rst_grant", 64'(grant_o), 64'b0001);
        advance();
        drive_idle();
        tick();
        tick();

        // Randomized traffic against the model, with quiet windows for stalls.
        for (int n = 0; n < 3000; n++) begin
            bit quiet;
            quiet = ((n / 150) % 3) == 2;
            for (int c = 0; c < NCH; c++) begin
                if (ch_cyc_i[c]) begin
                    if ($urandom_range(quiet ? 39 : 5) == 0) ch_cyc_i[c] = 1'b0;
                end else begin
                    if ($urandom_range(2) == 0) ch_cyc_i[c] = 1'b1;
                end
                ch_stb_i[c] = ch_cyc_i[c] & (quiet || ($urandom_range(3) != 0));
                ch_we_i[c]  = 1'($urandom_range(1));
                ch_cab_i[c] = 1'($urandom_range(1));
                ch_sel_i[c*4 +: 4]   = 4'($urandom_range(15));
                ch_adr_i[c*32 +: 32] = $urandom;
                ch_dat_i[c*DW +: DW] = {$urandom, $urandom};
            end
            m_ack_i = quiet ? ($urandom_range(63) == 0) : ($urandom_range(4) == 0);
            m_rty_i = quiet ? 1'b0 : ($urandom_range(15) == 0);
            m_err_i = quiet ? 1'b0 : ($urandom_range(15) == 0);
            m_dat_i = {$urandom, $urandom};
            if ($urandom_range(499) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
